// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM pipeline control slice.
package arm_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } pctrl_state_t;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/pctrl_hazard_detect.sv
// Combinational RAW / load-use hazard term for the instruction sitting in ID.
module pctrl_hazard_detect
    import arm_pkg::*;
(
    input  logic       fwd_en,
    input  logic [3:0] src1_id,
    input  logic [3:0] src2_id,
    input  logic       two_src_id,
    input  logic [3:0] exe_dest,
    input  logic       exe_wb_en,
    input  logic       exe_mem_r_en,
    input  logic [3:0] mem_dest,
    input  logic       mem_wb_en,
    output logic       hz
);

    logic exe_match_s;
    logic mem_match_s;

    assign exe_match_s = (src1_id == exe_dest) | (two_src_id & (src2_id == exe_dest));
    assign mem_match_s = (src1_id == mem_dest) | (two_src_id & (src2_id == mem_dest));

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign hz = fwd_en ? (exe_mem_r_en & exe_wb_en & exe_match_s)
                       : ((exe_wb_en & exe_match_s) | (mem_wb_en & mem_match_s));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: freeze/flush generation, post-reset hold, SRAM wait
// handling with timeout halt, and saturating performance counters.
module pipeline_ctrl
    import arm_pkg::*;
#(
    parameter int RESET_HOLD  = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [3:0]       src1_id,
    input  logic [3:0]       src2_id,
    input  logic             two_src_id,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             flush_if,
    output logic             flush_id,
    output logic             freeze_back,
    output logic             hazard,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pctrl_state_t     state_r;
    pctrl_state_t     state_s;
    logic [3:0]       hold_cnt_r;
    logic [9:0]       wait_cnt_r;
    logic             mem_timeout_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             hz_s;
    logic             memstall_s;
    logic             br_flush_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    pctrl_hazard_detect u_hazard (
        .fwd_en       (fwd_en),
        .src1_id      (src1_id),
        .src2_id      (src2_id),
        .two_src_id   (two_src_id),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hz           (hz_s)
    );

    assign memstall_s = mem_access & ~mem_ready;

    // Next-state and freeze/flush decode; stalled branches stay in EXE_Reg and apply on release.
    always_comb begin
        state_s     = state_r;
        freeze_pc   = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        freeze_back = 1'b0;
        hazard      = 1'b0;
        br_flush_s  = 1'b0;
        case (state_r)
            INIT: begin
                freeze_pc = 1'b1;
                flush_if  = 1'b1;
                flush_id  = 1'b1;
                if (hold_cnt_r == 4'(RESET_HOLD - 1)) begin
                    state_s = RUN;
                end else begin
                    state_s = INIT;
                end
            end
            RUN, MEM_WAIT: begin
                if ((state_r == RUN) ? memstall_s : ~mem_ready) begin
                    freeze_pc   = 1'b1;
                    freeze_back = 1'b1;
                    if (state_r == RUN) begin
                        state_s = MEM_WAIT;
                    end else if (wait_cnt_r == 10'(MEM_TIMEOUT - 1)) begin
                        state_s = HALT;
                    end else begin
                        state_s = MEM_WAIT;
                    end
                end else if (branch_taken) begin
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    br_flush_s = 1'b1;
                    state_s    = RUN;
                end else if (hz_s) begin
                    freeze_pc = 1'b1;
                    flush_id  = 1'b1;
                    hazard    = 1'b1;
                    state_s   = RUN;
                end else begin
                    state_s = RUN;
                end
            end
            HALT: begin
                freeze_pc   = 1'b1;
                freeze_back = 1'b1;
                state_s     = HALT;
            end
            default: begin
                state_s = INIT;
            end
        endcase
    end

    // State, hold/wait counters and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= INIT;
            hold_cnt_r    <= 4'd0;
            wait_cnt_r    <= 10'd0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == INIT) && (state_s == INIT)) begin
                hold_cnt_r <= hold_cnt_r + 4'd1;
            end else begin
                hold_cnt_r <= 4'd0;
            end
            // Counts stall cycles already spent, including the one that entered MEM_WAIT.
            if (state_s == MEM_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 10'd1;
            end else begin
                wait_cnt_r <= 10'd0;
            end
            if (state_s == HALT) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r  <= sat_inc(stall_cnt_r, freeze_back);
            bubble_cnt_r <= sat_inc(bubble_cnt_r, hazard);
            flush_cnt_r  <= sat_inc(flush_cnt_r, br_flush_s);
        end
    end

    assign mem_timeout = mem_timeout_r;
    assign stall_cnt   = stall_cnt_r;
    assign bubble_cnt  = bubble_cnt_r;
    assign flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int RESET_HOLD  = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, fwd_en, two_src_id, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic branch_taken, mem_access, mem_ready;
    logic [3:0] src1_id, src2_id, exe_dest, mem_dest;
    logic freeze_pc, flush_if, flush_id, freeze_back, hazard, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;

    pipeline_ctrl #(
        .RESET_HOLD  (RESET_HOLD),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fwd_en       (fwd_en),
        .src1_id      (src1_id),
        .src2_id      (src2_id),
        .two_src_id   (two_src_id),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .branch_taken (branch_taken),
        .mem_access   (mem_access),
        .mem_ready    (mem_ready),
        .freeze_pc    (freeze_pc),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .freeze_back  (freeze_back),
        .hazard       (hazard),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: remaining hold cycles, consecutive stall count, halted flag.
    int     m_hold_left;
    int     m_stalls;
    bit     m_waiting;
    bit     m_halt;
    longint m_stall_cnt, m_bubble_cnt, m_flush_cnt;

    logic obs_fp, obs_fi, obs_fid, obs_fb, obs_hz, obs_to;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_hz();
        bit m1, m2, n1, n2;
        m1 = (src1_id == exe_dest);
        m2 = two_src_id && (src2_id == exe_dest);
        n1 = (src1_id == mem_dest);
        n2 = two_src_id && (src2_id == mem_dest);
        if (fwd_en) return exe_mem_r_en && exe_wb_en && (m1 || m2);
        else        return (exe_wb_en && (m1 || m2)) || (mem_wb_en && (n1 || n2));
    endfunction

    task automatic model_reset();
        m_hold_left  = RESET_HOLD;
        m_stalls     = 0;
        m_waiting    = 1'b0;
        m_halt       = 1'b0;
        m_stall_cnt  = 0;
        m_bubble_cnt = 0;
        m_flush_cnt  = 0;
    endtask

    task automatic idle();
        rst = 1'b0; fwd_en = 1'b1; two_src_id = 1'b0;
        src1_id = 4'd0; src2_id = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_access = 1'b0; mem_ready = 1'b1;
    endtask

    // One clock: inputs already driven at the falling edge; check, then advance the model.
    task automatic cycle();
        bit e_fp, e_fi, e_fid, e_fb, e_hz, stall, in_init;
        e_fp = 0; e_fi = 0; e_fid = 0; e_fb = 0; e_hz = 0; stall = 0;
        in_init = (m_hold_left > 0);
        #1;
        obs_fp = freeze_pc; obs_fi = flush_if; obs_fid = flush_id;
        obs_fb = freeze_back; obs_hz = hazard; obs_to = mem_timeout;
        check_value("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
        check_value("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble_cnt));
        check_value("flush_cnt", 64'(flush_cnt), 64'(m_flush_cnt));
        check_value("mem_timeout", 64'(mem_timeout), 64'(m_halt));
        if (in_init) begin
            e_fp = 1; e_fi = 1; e_fid = 1;
        end else if (m_halt) begin
            e_fp = 1; e_fb = 1;
        end else begin
            stall = m_waiting ? !mem_ready : (mem_access && !mem_ready);
            if (stall) begin
                e_fp = 1; e_fb = 1;
            end else if (branch_taken) begin
                e_fi = 1; e_fid = 1;
            end else if (ref_hz()) begin
                e_fp = 1; e_fid = 1; e_hz = 1;
            end
        end
        if (!rst) begin
            check_value("freeze_pc", 64'(freeze_pc), 64'(e_fp));
            check_value("flush_if", 64'(flush_if), 64'(e_fi));
            check_value("flush_id", 64'(flush_id), 64'(e_fid));
            check_value("freeze_back", 64'(freeze_back), 64'(e_fb));
            check_value("hazard", 64'(hazard), 64'(e_hz));
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_stall_cnt  += e_fb;
            m_bubble_cnt += e_hz;
            m_flush_cnt  += (e_fi && !in_init);
            if (in_init) begin
                m_hold_left--;
            end else if (!m_halt) begin
                if (stall) begin
                    m_stalls++;
                    m_waiting = 1'b1;
                    if (m_stalls == MEM_TIMEOUT) begin
                        m_halt    = 1'b1;
                        m_waiting = 1'b0;
                    end
                end else begin
                    m_waiting = 1'b0;
                    m_stalls  = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        cycle();

        // Post-reset hold length
        rst = 1'b0;
        n = 0;
        repeat (6) begin cycle(); n += int'(obs_fp); end
        check_value("reset_hold_len", 64'(n), 64'd4);

        // Load-use with forwarding
        exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3; src1_id = 4'd3;
        cycle();
        check_value("load_use_hazard", 64'(obs_hz), 64'd1);
        idle(); cycle();
        check_value("load_use_bubble_cnt", 64'(bubble_cnt), 64'd1);

        // No-forward RAW via second source
        fwd_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd5; two_src_id = 1'b1; src2_id = 4'd5;
        cycle();
        check_value("nofwd_two_src", 64'(obs_hz), 64'd1);
        two_src_id = 1'b0;
        cycle();
        check_value("nofwd_one_src", 64'(obs_hz), 64'd0);

        // Branch wins over a simultaneous hazard
        idle();
        exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3; src1_id = 4'd3; branch_taken = 1'b1;
        cycle();
        check_value("br_flush_if", 64'(obs_fi), 64'd1);
        check_value("br_freeze_pc", 64'(obs_fp), 64'd0);
        check_value("br_hazard", 64'(obs_hz), 64'd0);
        idle(); cycle();
        check_value("br_flush_cnt", 64'(flush_cnt), 64'd1);

        // SRAM wait of three cycles, then a zero-wait access
        mem_access = 1'b1; mem_ready = 1'b0;
        n = 0;
        repeat (3) begin cycle(); n += int'(obs_fb); end
        mem_ready = 1'b1; cycle(); n += int'(obs_fb);
        idle(); cycle(); n += int'(obs_fb);
        check_value("sram_wait_stalls", 64'(n), 64'd3);
        check_value("sram_stall_cnt", 64'(stall_cnt), 64'd3);
        mem_access = 1'b1; mem_ready = 1'b1;
        cycle();
        check_value("zero_wait_fb", 64'(obs_fb), 64'd0);
        idle(); cycle();
        check_value("zero_wait_stall_cnt", 64'(stall_cnt), 64'd3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            fwd_en       = 1'($urandom_range(0, 1));
            src1_id      = 4'($urandom_range(0, 3));
            src2_id      = 4'($urandom_range(0, 3));
            two_src_id   = 1'($urandom_range(0, 1));
            exe_dest     = 4'($urandom_range(0, 3));
            mem_dest     = 4'($urandom_range(0, 3));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 99) < 15);
            mem_access   = ($urandom_range(0, 9) < 3);
            mem_ready    = ($urandom_range(0, 9) < 6);
            cycle();
        end

        // Memory timeout, stickiness, and recovery through reset
        idle(); rst = 1'b1; cycle();
        rst = 1'b0;
        repeat (RESET_HOLD + 1) cycle();
        mem_access = 1'b1; mem_ready = 1'b0;
        n = 0;
        repeat (12) begin
            cycle();
            if (!obs_to && obs_fb) n++;
        end
        check_value("timeout_stalls", 64'(n), 64'd8);
        idle();
        repeat (3) cycle();
        check_value("timeout_sticky", 64'(obs_to), 64'd1);
        check_value("halt_freeze_back", 64'(obs_fb), 64'd1);
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        check_value("post_rst_timeout", 64'(obs_to), 64'd0);
        check_value("post_rst_init", 64'(obs_fp), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
